cluster_count_monitor: RTL and testbench
========================================

Name: cluster_count_monitor

Overview:
- Sits directly downstream of the cluster-counting pipeline.
- Consumes that pipeline's per-BX cluster count and overflow flag, and builds statistics over a fixed window of WINDOW_BX bunch crossings: summed count, peak count and number of overflow BXs.
- At the end of each window the results are snapshotted into output registers and offered to slow-control/DAQ readout through a valid/ack handshake. Windows completed while a snapshot is still pending are counted as dropped.

Parameters:
- CNT_WIDTH, 11, width of the incoming cluster count.
- WINDOW_BX, 1024, number of sampled BXs per window; legal range 2..65535.
- SUM_WIDTH, 24, width of the saturating window sum.
- OVF_WIDTH, 16, width of the saturating overflow-BX counter.
- DROP_WIDTH, 8, width of the saturating dropped-window counter.

Ports:
- clock4x  in  1  fabric clock, 4x the BX rate.
- reset  in  1  synchronous, active-high reset.
- enable_i  in  1  run/stop control.
- bx_strobe_i  in  1  one-cycle pulse marking cnt_i/overflow_i as this BX's valid sample.
- cnt_i  in  CNT_WIDTH  cluster count for the BX.
- overflow_i  in  1  overflow flag for the BX.
- result_valid_o  out  1  snapshot available.
- result_ack_i  in  1  consumer accepts the snapshot.
- sum_o  out  SUM_WIDTH  window sum of cnt_i.
- max_o  out  CNT_WIDTH  window peak of cnt_i.
- ovf_cnt_o  out  OVF_WIDTH  number of BXs in the window with overflow_i=1.
- drop_cnt_o  out  DROP_WIDTH  windows lost because a snapshot was still pending.
- busy_o  out  1  high while in RUN.

Behaviour:
- Clocking and reset:
  - Single clock, clock4x; reset is synchronous and active-high.
  - Reset clears all outputs, accumulators and the window counter to 0 and forces IDLE.
  - Reset asserted mid-window or mid-handshake discards everything, with no partial snapshot.
- State machine, two states:
  - IDLE to RUN on the cycle after enable_i=1 is sampled.
  - RUN to IDLE on the cycle after enable_i=0 is sampled.
  - Entering IDLE clears the accumulators and window counter.
  - Output registers, result_valid_o and drop_cnt_o are preserved in IDLE, and the handshake still operates there.
- busy_o is 1 exactly in RUN.
- Sampling:
  - A sample is taken only when the state is RUN and bx_strobe_i=1. Strobes in IDLE are ignored.
  - bx_strobe_i is not assumed to have any particular spacing; back-to-back strobes are legal.
- Per-sample arithmetic, with unsigned accumulators:
  - sum_acc += cnt_i, saturating at all-ones.
  - max_acc = max(max_acc, cnt_i).
  - ovf_acc += overflow_i, saturating.
- Window counter counts samples 0..WINDOW_BX-1.
- On the sample where the counter equals WINDOW_BX-1:
  - Snapshot values include that final sample.
  - The accumulators and window counter reload to 0 in the same edge, so the next sample starts a fresh window with no gap.
- Snapshot load, evaluated at the same edge as the final sample:
  - If result_valid_o=0, or result_ack_i=1 in that cycle: load sum_o, max_o and ovf_cnt_o, and drive result_valid_o=1 on the next cycle. This is 1-cycle latency from the final strobe.
  - Otherwise: outputs are unchanged and drop_cnt_o increments, saturating at all-ones.
- Handshake:
  - result_valid_o holds, with stable data, until result_ack_i=1 is sampled while valid is high. It then clears next cycle unless a new snapshot loads in that same cycle, in which case valid stays 1 with the new data.
  - result_ack_i while valid is low has no effect.
- drop_cnt_o is cleared only by reset.
- cnt_i values are used as given, with no range checking.

Test Plan:
- WINDOW_BX=4, enable=1, strobes every 4th cycle with cnt_i=3,7,1,5 and overflow_i=0,1,0,1 -> one cycle after the 4th strobe: valid=1, sum_o=16, max_o=7, ovf_cnt_o=2, drop_cnt_o=0. Ack -> valid=0 next cycle.
- Same stimulus continued for 3 windows with no ack -> outputs still show the first window, drop_cnt_o=2. Ack asserted in the same cycle as the 4th window's final strobe -> new snapshot loads and valid stays 1.
- SUM_WIDTH=8, WINDOW_BX=4, cnt_i=100 every strobe -> sum_o=255 (saturated), max_o=100. Also check DROP_WIDTH saturation at 255 after 260 unacknowledged windows.
- enable drops after 2 of 4 samples, strobes continue, enable re-asserts -> no snapshot emitted. The next window counts only post-re-enable samples: 4 samples of cnt_i=2 give sum_o=8. A pending snapshot survives the enable drop and is still ackable.
- Reset pulsed mid-window with valid=1 -> every output is 0 the cycle after reset and busy_o=0. Post-reset windows start counting from sample 0.
- Back-to-back strobes (every cycle) with cnt_i=1536, overflow_i=1, WINDOW_BX=2 -> a snapshot every 2 cycles with sum_o=3072, max_o=1536, ovf_cnt_o=2, acked each cycle with no drops.

Source files
------------

// File: rtl/cluster_count_monitor_if.sv
// cluster_count_monitor_if
//
// Bundles the sample stream, run control and result readout of
// cluster_count_monitor.
//   enable_i       run/stop control
//   bx_strobe_i    marks cnt_i/overflow_i as this BX's valid sample
//   cnt_i          cluster count for the BX
//   overflow_i     overflow flag for the BX
//   result_ack_i   consumer accepts the current snapshot
//   result_valid_o snapshot available
//   sum_o          saturated window sum of cnt_i
//   max_o          window peak of cnt_i
//   ovf_cnt_o      number of BXs in the window with overflow_i set
//   drop_cnt_o     windows lost while a snapshot was pending
//   busy_o         high while the monitor is running
//
// master: the environment (pipeline + readout) side.
// slave:  the monitor itself.
interface cluster_count_monitor_if #(
    parameter int unsigned CNT_WIDTH  = 11,
    parameter int unsigned SUM_WIDTH  = 24,
    parameter int unsigned OVF_WIDTH  = 16,
    parameter int unsigned DROP_WIDTH = 8
);
    logic                  enable_i;
    logic                  bx_strobe_i;
    logic [CNT_WIDTH-1:0]  cnt_i;
    logic                  overflow_i;
    logic                  result_ack_i;
    logic                  result_valid_o;
    logic [SUM_WIDTH-1:0]  sum_o;
    logic [CNT_WIDTH-1:0]  max_o;
    logic [OVF_WIDTH-1:0]  ovf_cnt_o;
    logic [DROP_WIDTH-1:0] drop_cnt_o;
    logic                  busy_o;

    modport master (
        output enable_i, bx_strobe_i, cnt_i, overflow_i, result_ack_i,
        input  result_valid_o, sum_o, max_o, ovf_cnt_o, drop_cnt_o, busy_o
    );

    modport slave (
        input  enable_i, bx_strobe_i, cnt_i, overflow_i, result_ack_i,
        output result_valid_o, sum_o, max_o, ovf_cnt_o, drop_cnt_o, busy_o
    );
endinterface

// File: rtl/cluster_count_monitor.sv
// cluster_count_monitor
//
// Collects per-BX cluster-count statistics over windows of WINDOW_BX sampled
// BXs (saturated sum, peak, overflow-BX count) and offers each completed
// window as a snapshot through a valid/ack handshake. Windows that complete
// while a snapshot is still pending are counted as dropped.
//
// Ports:
//   clock4x  fabric clock (4x BX rate)
//   reset    synchronous, active-high reset
//   bus      cluster_count_monitor_if.slave: sample stream, enable,
//            result handshake and statistics outputs
module cluster_count_monitor #(
    parameter int unsigned CNT_WIDTH  = 11,
    parameter int unsigned WINDOW_BX  = 1024,
    parameter int unsigned SUM_WIDTH  = 24,
    parameter int unsigned OVF_WIDTH  = 16,
    parameter int unsigned DROP_WIDTH = 8
) (
    input logic                     clock4x,
    input logic                     reset,
    cluster_count_monitor_if.slave  bus
);

    localparam int unsigned WinW = $clog2(WINDOW_BX);
    localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_BX - 1);
    // Sum is formed one bit wider than either operand so overflow is visible.
    localparam int unsigned SumExtW = ((SUM_WIDTH > CNT_WIDTH) ? SUM_WIDTH : CNT_WIDTH) + 1;
    localparam logic [SumExtW-1:0] SumSat = SumExtW'({SUM_WIDTH{1'b1}});

    typedef enum logic {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [WinW-1:0]       win_cnt_q, win_cnt_d;
    logic [SUM_WIDTH-1:0]  sum_acc_q, sum_acc_d;
    logic [CNT_WIDTH-1:0]  max_acc_q, max_acc_d;
    logic [OVF_WIDTH-1:0]  ovf_acc_q, ovf_acc_d;

    logic                  valid_q, valid_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [CNT_WIDTH-1:0]  max_q, max_d;
    logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic                  sample;
    logic                  last;
    logic                  load;
    logic                  drop;
    logic [SumExtW-1:0]    sum_ext;
    logic [SUM_WIDTH-1:0]  sum_upd;
    logic [CNT_WIDTH-1:0]  max_upd;
    logic [OVF_WIDTH-1:0]  ovf_upd;

    assign sample = (state_q == StRun) && bus.bx_strobe_i;
    assign last   = sample && (win_cnt_q == WinLast);

    // Accumulator values including the current sample; these also feed the
    // snapshot so the final sample of a window is part of its result.
    always_comb begin
        sum_ext = SumExtW'(sum_acc_q) + SumExtW'(bus.cnt_i);
        sum_upd = (sum_ext > SumSat) ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
        max_upd = (bus.cnt_i > max_acc_q) ? bus.cnt_i : max_acc_q;
        ovf_upd = ovf_acc_q;
        if (bus.overflow_i && (ovf_acc_q != {OVF_WIDTH{1'b1}})) begin
            ovf_upd = ovf_acc_q + OVF_WIDTH'(1);
        end
    end

    // State machine and window accumulation.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        sum_acc_d = sum_acc_q;
        max_acc_d = max_acc_q;
        ovf_acc_d = ovf_acc_q;

        if (state_q == StIdle) begin
            if (bus.enable_i) begin
                state_d = StRun;
            end
        end else begin
            if (sample) begin
                if (last) begin
                    // Fresh window starts on the very next sample.
                    win_cnt_d = '0;
                    sum_acc_d = '0;
                    max_acc_d = '0;
                    ovf_acc_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WinW'(1);
                    sum_acc_d = sum_upd;
                    max_acc_d = max_upd;
                    ovf_acc_d = ovf_upd;
                end
            end
            // Leaving RUN abandons the partial window.
            if (!bus.enable_i) begin
                state_d   = StIdle;
                win_cnt_d = '0;
                sum_acc_d = '0;
                max_acc_d = '0;
                ovf_acc_d = '0;
            end
        end
    end

    // Snapshot registers and readout handshake; active in both states.
    always_comb begin
        load    = last && (!valid_q || bus.result_ack_i);
        drop    = last && !load;
        valid_d = valid_q;
        sum_d   = sum_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;

        if (load) begin
            valid_d = 1'b1;
            sum_d   = sum_upd;
            max_d   = max_upd;
            ovf_d   = ovf_upd;
        end else if (valid_q && bus.result_ack_i) begin
            valid_d = 1'b0;
        end

        if (drop && (drop_q != {DROP_WIDTH{1'b1}})) begin
            drop_d = drop_q + DROP_WIDTH'(1);
        end
    end

    always_ff @(posedge clock4x) begin
        if (reset) begin
            state_q   <= StIdle;
            win_cnt_q <= '0;
            sum_acc_q <= '0;
            max_acc_q <= '0;
            ovf_acc_q <= '0;
            valid_q   <= 1'b0;
            sum_q     <= '0;
            max_q     <= '0;
            ovf_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            sum_acc_q <= sum_acc_d;
            max_acc_q <= max_acc_d;
            ovf_acc_q <= ovf_acc_d;
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            max_q     <= max_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.result_valid_o = valid_q;
    assign bus.sum_o          = sum_q;
    assign bus.max_o          = max_q;
    assign bus.ovf_cnt_o      = ovf_q;
    assign bus.drop_cnt_o     = drop_q;
    assign bus.busy_o         = (state_q == StRun);

endmodule

// File: tb/tb_cluster_count_monitor.sv
// Bench for cluster_count_monitor: two instances share one stimulus stream.
//   a: WINDOW_BX=4, SUM_WIDTH=8  (window and sum-saturation cases)
//   b: WINDOW_BX=2, SUM_WIDTH=24 (back-to-back window case)
// A window-level reference model (plain sums/max, saturation applied with
// min()) predicts every output of both instances each cycle.
module tb_cluster_count_monitor;

    localparam int unsigned WinA = 4;
    localparam int unsigned WinB = 2;
    localparam longint SatA    = 255;
    localparam longint SatB    = 16777215;
    localparam longint SatOvf  = 65535;
    localparam longint SatDrop = 255;

    logic        clock4x = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        strobe  = 1'b0;
    logic [10:0] cnt     = '0;
    logic        ovf     = 1'b0;
    logic        ack     = 1'b0;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    always #5 clock4x = ~clock4x;

    cluster_count_monitor_if #(.CNT_WIDTH(11), .SUM_WIDTH(8), .OVF_WIDTH(16), .DROP_WIDTH(8))
        bus_a ();
    cluster_count_monitor_if #(.CNT_WIDTH(11), .SUM_WIDTH(24), .OVF_WIDTH(16), .DROP_WIDTH(8))
        bus_b ();

    assign bus_a.enable_i     = enable;
    assign bus_a.bx_strobe_i  = strobe;
    assign bus_a.cnt_i        = cnt;
    assign bus_a.overflow_i   = ovf;
    assign bus_a.result_ack_i = ack;
    assign bus_b.enable_i     = enable;
    assign bus_b.bx_strobe_i  = strobe;
    assign bus_b.cnt_i        = cnt;
    assign bus_b.overflow_i   = ovf;
    assign bus_b.result_ack_i = ack;

    cluster_count_monitor #(
        .CNT_WIDTH(11), .WINDOW_BX(WinA), .SUM_WIDTH(8), .OVF_WIDTH(16), .DROP_WIDTH(8)
    ) dut_a (
        .clock4x (clock4x),
        .reset   (reset),
        .bus     (bus_a)
    );

    cluster_count_monitor #(
        .CNT_WIDTH(11), .WINDOW_BX(WinB), .SUM_WIDTH(24), .OVF_WIDTH(16), .DROP_WIDTH(8)
    ) dut_b (
        .clock4x (clock4x),
        .reset   (reset),
        .bus     (bus_b)
    );

    // ---------------- reference model ----------------
    bit     m_run  [2];
    int     m_n    [2];
    longint m_sum  [2];
    int     m_mx   [2];
    int     m_ov   [2];
    bit     e_valid[2];
    longint e_sum  [2];
    longint e_max  [2];
    longint e_ovf  [2];
    longint e_drop [2];

    task automatic model_step(input int i);
        longint w;
        longint sat;
        bit     done;
        longint s;
        longint mx;
        longint ov;
        w    = (i == 0) ? longint'(WinA) : longint'(WinB);
        sat  = (i == 0) ? SatA : SatB;
        done = 1'b0;
        s    = 0;
        mx   = 0;
        ov   = 0;
        if (reset) begin
            m_run[i] = 1'b0; m_n[i] = 0; m_sum[i] = 0; m_mx[i] = 0; m_ov[i] = 0;
            e_valid[i] = 1'b0; e_sum[i] = 0; e_max[i] = 0; e_ovf[i] = 0; e_drop[i] = 0;
            return;
        end
        if (m_run[i] && strobe) begin
            m_n[i]   = m_n[i] + 1;
            m_sum[i] = m_sum[i] + longint'(cnt);
            if (int'(cnt) > m_mx[i]) m_mx[i] = int'(cnt);
            m_ov[i]  = m_ov[i] + (ovf ? 1 : 0);
            if (longint'(m_n[i]) == w) begin
                done = 1'b1;
                s    = (m_sum[i] > sat) ? sat : m_sum[i];
                mx   = longint'(m_mx[i]);
                ov   = (longint'(m_ov[i]) > SatOvf) ? SatOvf : longint'(m_ov[i]);
                m_n[i] = 0; m_sum[i] = 0; m_mx[i] = 0; m_ov[i] = 0;
            end
        end
        if (done && (!e_valid[i] || ack)) begin
            e_valid[i] = 1'b1;
            e_sum[i]   = s;
            e_max[i]   = mx;
            e_ovf[i]   = ov;
        end else if (done) begin
            e_drop[i] = (e_drop[i] + 1 > SatDrop) ? SatDrop : e_drop[i] + 1;
        end else if (e_valid[i] && ack) begin
            e_valid[i] = 1'b0;
        end
        if (m_run[i] && !enable) begin
            m_n[i] = 0; m_sum[i] = 0; m_mx[i] = 0; m_ov[i] = 0;
        end
        m_run[i] = enable;
    endtask

    always @(posedge clock4x) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_total = n_total + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("a.valid", longint'(bus_a.result_valid_o), longint'(e_valid[0]));
        check_eq("a.busy",  longint'(bus_a.busy_o),         longint'(m_run[0]));
        check_eq("a.sum",   longint'(bus_a.sum_o),          e_sum[0]);
        check_eq("a.max",   longint'(bus_a.max_o),          e_max[0]);
        check_eq("a.ovf",   longint'(bus_a.ovf_cnt_o),      e_ovf[0]);
        check_eq("a.drop",  longint'(bus_a.drop_cnt_o),     e_drop[0]);
        check_eq("b.valid", longint'(bus_b.result_valid_o), longint'(e_valid[1]));
        check_eq("b.busy",  longint'(bus_b.busy_o),         longint'(m_run[1]));
        check_eq("b.sum",   longint'(bus_b.sum_o),          e_sum[1]);
        check_eq("b.max",   longint'(bus_b.max_o),          e_max[1]);
        check_eq("b.ovf",   longint'(bus_b.ovf_cnt_o),      e_ovf[1]);
        check_eq("b.drop",  longint'(bus_b.drop_cnt_o),     e_drop[1]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock4x);
        #1;
        if (chk_en) compare_all();
    endtask

    task automatic drive(input bit s, input int c, input bit o, input bit a);
        strobe = s;
        cnt    = c[10:0];
        ovf    = o;
        ack    = a;
    endtask

    task automatic pulse(input int c, input bit o, input bit a);
        drive(1'b1, c, o, a);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int t1_cnt [4] = '{3, 7, 1, 5};
    bit t1_ovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int t2_cnt [4] = '{10, 20, 30, 40};

    initial begin
        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst.valid", longint'(bus_a.result_valid_o), 0);
        check_eq("rst.busy",  longint'(bus_a.busy_o), 0);
        check_eq("rst.sum",   longint'(bus_a.sum_o), 0);
        check_eq("rst.drop",  longint'(bus_a.drop_cnt_o), 0);

        // Basic window, strobes every 4th cycle
        enable = 1'b1;
        tick();
        check_eq("run.busy", longint'(bus_a.busy_o), 1);
        for (int k = 0; k < 4; k++) begin
            pulse(t1_cnt[k], t1_ovf[k], 1'b0);
            idle(3);
        end
        // The final strobe's cycle is 4 ticks back; replay one window directly
        // to check the 1-cycle latency point.
        pulse(3, 1'b0, 1'b1);   // ack the pending snapshot, starts next window
        check_eq("t1.ackclr", longint'(bus_a.result_valid_o), 0);
        idle(3);
        for (int k = 1; k < 4; k++) begin
            pulse(t1_cnt[k], t1_ovf[k], 1'b0);
            if (k == 3) begin
                check_eq("t1.valid", longint'(bus_a.result_valid_o), 1);
                check_eq("t1.sum",   longint'(bus_a.sum_o), 16);
                check_eq("t1.max",   longint'(bus_a.max_o), 7);
                check_eq("t1.ovf",   longint'(bus_a.ovf_cnt_o), 2);
                check_eq("t1.drop",  longint'(bus_a.drop_cnt_o), 0);
            end
            idle(3);
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        check_eq("t1.ack", longint'(bus_a.result_valid_o), 0);

        // Three unacked windows: first loads, next two dropped
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 4; k++) begin
                pulse(t1_cnt[k], t1_ovf[k], 1'b0);
                idle(3);
            end
        end
        check_eq("t2.sum",  longint'(bus_a.sum_o), 16);
        check_eq("t2.drop", longint'(bus_a.drop_cnt_o), 2);
        // Ack coincides with final strobe: new data loads, valid stays high
        for (int k = 0; k < 4; k++) begin
            pulse(t2_cnt[k], 1'b1, k == 3);
            if (k == 3) begin
                check_eq("t2.valid", longint'(bus_a.result_valid_o), 1);
                check_eq("t2.nsum",  longint'(bus_a.sum_o), 100);
                check_eq("t2.nmax",  longint'(bus_a.max_o), 40);
                check_eq("t2.novf",  longint'(bus_a.ovf_cnt_o), 4);
                check_eq("t2.ndrop", longint'(bus_a.drop_cnt_o), 2);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);

        // Sum saturation, then 260 unacked random windows saturate drop count
        for (int k = 0; k < 4; k++) pulse(100, 1'b0, 1'b0);
        check_eq("t3.sum", longint'(bus_a.sum_o), 255);
        check_eq("t3.max", longint'(bus_a.max_o), 100);
        for (int k = 0; k < 260 * 4; k++) begin
            pulse(int'($urandom_range(0, 2047)), $urandom_range(0, 1) == 1, 1'b0);
        end
        check_eq("t3.drop",  longint'(bus_a.drop_cnt_o), 255);
        check_eq("t3.bdrop", longint'(bus_b.drop_cnt_o), 255);
        check_eq("t3.hold",  longint'(bus_a.sum_o), 255);

        // Enable drop mid-window; pending snapshot survives and is ackable
        pulse(9, 1'b0, 1'b0);
        pulse(9, 1'b0, 1'b0);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) pulse(50, 1'b1, 1'b0);
        check_eq("t4.busy",  longint'(bus_a.busy_o), 0);
        check_eq("t4.valid", longint'(bus_a.result_valid_o), 1);
        check_eq("t4.sum",   longint'(bus_a.sum_o), 255);
        drive(1'b0, 0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        check_eq("t4.ack", longint'(bus_a.result_valid_o), 0);
        enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            pulse(2, 1'b0, 1'b0);
            if (k == 2) check_eq("t4.nosnap", longint'(bus_a.result_valid_o), 0);
        end
        check_eq("t4.sum8", longint'(bus_a.sum_o), 8);
        check_eq("t4.max2", longint'(bus_a.max_o), 2);

        // Reset mid-window with a snapshot pending
        pulse(7, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("t5.valid", longint'(bus_a.result_valid_o), 0);
        check_eq("t5.sum",   longint'(bus_a.sum_o), 0);
        check_eq("t5.max",   longint'(bus_a.max_o), 0);
        check_eq("t5.ovf",   longint'(bus_a.ovf_cnt_o), 0);
        check_eq("t5.drop",  longint'(bus_a.drop_cnt_o), 0);
        check_eq("t5.busy",  longint'(bus_a.busy_o), 0);
        tick();
        for (int k = 0; k < 4; k++) pulse(1, 1'b0, 1'b1);
        check_eq("t5.sum4", longint'(bus_a.sum_o), 4);
        check_eq("t5.max1", longint'(bus_a.max_o), 1);

        // Back-to-back strobes, ack held high, WINDOW_BX=2 instance
        for (int j = 1; j <= 20; j++) begin
            drive(1'b1, 1536, 1'b1, 1'b1);
            tick();
            if (j % 2 == 0) begin
                check_eq("t6.valid", longint'(bus_b.result_valid_o), 1);
                check_eq("t6.sum",   longint'(bus_b.sum_o), 3072);
                check_eq("t6.max",   longint'(bus_b.max_o), 1536);
                check_eq("t6.ovf",   longint'(bus_b.ovf_cnt_o), 2);
            end else begin
                check_eq("t6.clr", longint'(bus_b.result_valid_o), 0);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        check_eq("t6.bdrop", longint'(bus_b.drop_cnt_o), 0);
        check_eq("t6.adrop", longint'(bus_a.drop_cnt_o), 0);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 15) != 0);
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 2047)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
